// File: rtl/vram_arbiter_if.sv
// Bus bundle between vram_arbiter, the display fetcher, the system port and the canvas BRAM.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface vram_arbiter_if #(
  parameter int ADDRW = 14,
  parameter int DATAW = 32
);
  logic             disp_req;
  logic [ADDRW-1:0] disp_addr;
  logic             disp_ack;
  logic             disp_rvalid;
  logic [DATAW-1:0] disp_rdata;

  logic             sys_valid;
  logic             sys_ready;
  logic             sys_we;
  logic [ADDRW-1:0] sys_addr;
  logic [DATAW-1:0] sys_wdata;
  logic             sys_rvalid;
  logic [DATAW-1:0] sys_rdata;

  logic [ADDRW-1:0] mem_addr;
  logic             mem_we;
  logic [DATAW-1:0] mem_wdata;
  logic [DATAW-1:0] mem_rdata;

  logic [15:0]      stat_sys_stall;
  logic [15:0]      stat_bursts;

  modport slave (
    input  disp_req, disp_addr, sys_valid, sys_we, sys_addr, sys_wdata, mem_rdata,
    output disp_ack, disp_rvalid, disp_rdata, sys_ready, sys_rvalid, sys_rdata,
           mem_addr, mem_we, mem_wdata, stat_sys_stall, stat_bursts
  );

  modport master (
    output disp_req, disp_addr, sys_valid, sys_we, sys_addr, sys_wdata, mem_rdata,
    input  disp_ack, disp_rvalid, disp_rdata, sys_ready, sys_rvalid, sys_rdata,
           mem_addr, mem_we, mem_wdata, stat_sys_stall, stat_bursts
  );
endinterface

// File: rtl/vram_arbiter.sv
// Canvas BRAM arbiter: display bursts have priority, the system port is owed one beat per burst gap.
// Define VRAM_ARB_STATS_EN to build the stall and burst statistic counters.
module vram_arbiter #(
  parameter int ADDRW = 14,
  parameter int DATAW = 32,
  parameter int BURST = 8
) (
  input logic           clk,
  input logic           rst_n,
  vram_arbiter_if.slave bus
);
  localparam int CW = $clog2(BURST);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic {IDLE, BURST_ST} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ADDRW-1:0] base_q, base_d;
  logic             sysOwed_q, sysOwed_d;
  logic             dispRvalid_q, sysRvalid_q;

  logic             dispAck, sysReady, dispIssue, sysRead;
  logic [ADDRW-1:0] memAddr;
  logic             memWe;
  logic [DATAW-1:0] memWdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    sysOwed_d = sysOwed_q;
    dispAck   = 1'b0;
    sysReady  = 1'b0;
    dispIssue = 1'b0;
    sysRead   = 1'b0;
    memAddr   = '0;
    memWe     = 1'b0;
    memWdata  = '0;
    unique case (state_q)
      IDLE: begin
        // An owed system beat outranks a waiting display request.
        sysReady = !bus.disp_req || sysOwed_q;
        if (bus.sys_valid && sysReady) begin
          memAddr   = bus.sys_addr;
          memWe     = bus.sys_we;
          memWdata  = bus.sys_wdata;
          sysRead   = !bus.sys_we;
          sysOwed_d = 1'b0;
        end else if (bus.disp_req) begin
          dispAck   = 1'b1;
          dispIssue = 1'b1;
          memAddr   = bus.disp_addr;
          base_d    = bus.disp_addr;
          cnt_d     = CW'(1);
          state_d   = BURST_ST;
        end
        if (!bus.sys_valid) sysOwed_d = 1'b0;
      end
      BURST_ST: begin
        dispIssue = 1'b1;
        memAddr   = base_q + ADDRW'(cnt_q);
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          sysOwed_d = bus.sys_valid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      sysOwed_q    <= 1'b0;
      dispRvalid_q <= 1'b0;
      sysRvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      sysOwed_q    <= sysOwed_d;
      dispRvalid_q <= dispIssue;
      sysRvalid_q  <= sysRead;
    end
  end

  // The BRAM output is already registered, so read data passes straight through.
  assign bus.disp_ack    = dispAck;
  assign bus.sys_ready   = sysReady;
  assign bus.mem_addr    = memAddr;
  assign bus.mem_we      = memWe;
  assign bus.mem_wdata   = memWdata;
  assign bus.disp_rvalid = dispRvalid_q;
  assign bus.sys_rvalid  = sysRvalid_q;
  assign bus.disp_rdata  = bus.mem_rdata;
  assign bus.sys_rdata   = bus.mem_rdata;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q, bursts_q;
  logic        burstDone;

  assign burstDone = (state_q == BURST_ST) && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bursts_q <= '0;
    end else begin
      if (bus.sys_valid && !sysReady && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (burstDone) bursts_q <= bursts_q + 16'd1;
    end
  end

  assign bus.stat_sys_stall = stall_q;
  assign bus.stat_bursts    = bursts_q;
`else
  assign bus.stat_sys_stall = 16'h0000;
  assign bus.stat_bursts    = 16'h0000;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle-latency BRAM model behind the memory port.
// Per-cycle vectors are driven at negedge and compared 1 ns later.
module tb_vram_arbiter;
  localparam int ADDRW = 14;
  localparam int DATAW = 32;
  localparam int BURST = 8;

  typedef struct packed {
    logic             dreq;
    logic [ADDRW-1:0] daddr;
    logic             sval;
    logic             swe;
    logic [ADDRW-1:0] saddr;
    logic [DATAW-1:0] swdata;
    logic             ack;
    logic             rdy;
    logic [ADDRW-1:0] maddr;
    logic             mwe;
    logic             drv;
    logic             srv;
    logic [DATAW-1:0] rdata;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vram_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  vram_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATAW-1:0] mem [0:(1<<ADDRW)-1];

  function automatic logic [DATAW-1:0] memInit(input logic [ADDRW-1:0] a);
    return 32'hA500_0000 | {18'h0, a};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic dreq, input logic [ADDRW-1:0] daddr,
                              input logic sval, input logic swe, input logic [ADDRW-1:0] saddr,
                              input logic [DATAW-1:0] swdata, input logic ack, input logic rdy,
                              input logic [ADDRW-1:0] maddr, input logic mwe, input logic drv,
                              input logic srv, input logic [DATAW-1:0] rdata);
    vec_t v;
    v.dreq = dreq; v.daddr = daddr; v.sval = sval; v.swe = swe; v.saddr = saddr;
    v.swdata = swdata; v.ack = ack; v.rdy = rdy; v.maddr = maddr; v.mwe = mwe;
    v.drv = drv; v.srv = srv; v.rdata = rdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.disp_req  = v.dreq;
    bus.disp_addr = v.daddr;
    bus.sys_valid = v.sval;
    bus.sys_we    = v.swe;
    bus.sys_addr  = v.saddr;
    bus.sys_wdata = v.swdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkVec(input vec_t v, input string tag);
    checkOutput({tag, ".disp_ack"}, 32'(bus.disp_ack), 32'(v.ack));
    checkOutput({tag, ".sys_ready"}, 32'(bus.sys_ready), 32'(v.rdy));
    checkOutput({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(v.maddr));
    checkOutput({tag, ".mem_we"}, 32'(bus.mem_we), 32'(v.mwe));
    checkOutput({tag, ".disp_rvalid"}, 32'(bus.disp_rvalid), 32'(v.drv));
    checkOutput({tag, ".sys_rvalid"}, 32'(bus.sys_rvalid), 32'(v.srv));
    if (v.mwe) checkOutput({tag, ".mem_wdata"}, bus.mem_wdata, v.swdata);
    if (v.drv) checkOutput({tag, ".disp_rdata"}, bus.disp_rdata, v.rdata);
    if (v.srv) checkOutput({tag, ".sys_rdata"}, bus.sys_rdata, v.rdata);
  endtask

  task automatic cycle(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkVec(v, tag);
  endtask

  vec_t tbl [14];
  int   expStall;
  int   expBursts;

  initial begin
    logic [ADDRW-1:0] a, prevA;
    logic [ADDRW-1:0] sAddr;
    logic dreq, sval, ack, rdy, drv, srv, prevDisp, prevSysRd;
    int s;

    checks = 0;
    errors = 0;
    for (int i = 0; i < (1 << ADDRW); i++) mem[i] = memInit(ADDRW'(i));
    rst_n = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset.disp_rvalid", 32'(bus.disp_rvalid), 32'd0);
    checkOutput("reset.stat_sys_stall", 32'(bus.stat_sys_stall), 32'd0);
    checkOutput("reset.stat_bursts", 32'(bus.stat_bursts), 32'd0);
    rst_n = 1'b1;

    // Idle, system write, system read back, then a display burst at 0x0100.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 14'h0010, 32'hDEADBEEF, 0, 1, 14'h0010, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 14'h0010, 0,            0, 1, 14'h0010, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 0, 1, 32'hDEADBEEF);
    tbl[4]  = mk(1, 14'h0100, 0, 0, 0, 0,           1, 0, 14'h0100, 0, 0, 0, 0);
    for (int k = 1; k < BURST; k++)
      tbl[4+k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 14'h0100 + ADDRW'(k), 0, 1, 0,
                    memInit(14'h0100 + ADDRW'(k - 1)));
    tbl[12] = mk(0, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 1, 0, memInit(14'h0107));
    tbl[13] = mk(0, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cycle(tbl[i], $sformatf("row%0d", i));

    // Burst straddling the top of memory.
    for (int k = 0; k <= BURST; k++) begin
      a = 14'h3FFC + ADDRW'(k);
      cycle(mk(k == 0, 14'h3FFC, 0, 0, 0, 0, k == 0, k == BURST, (k < BURST) ? a : '0, 0,
               k >= 1, 0, memInit(a - 14'd1)), $sformatf("wrap%0d", k));
    end

    // Simultaneous requests from IDLE with nothing owed, display request kept up.
    prevA = '0; prevDisp = 0; prevSysRd = 0;
    for (int k = 0; k <= 17; k++) begin
      dreq = (k <= 9);
      sval = (k <= 8);
      ack  = (k == 0 || k == 9);
      rdy  = (k == 8 || k == 17);
      if (k < 8) a = 14'h0300 + ADDRW'(k);
      else if (k == 8) a = 14'h0030;
      else if (k < 17) a = 14'h0300 + ADDRW'(k - 9);
      else a = '0;
      cycle(mk(dreq, 14'h0300, sval, 0, 14'h0030, 0, ack, rdy, a, 0, prevDisp, prevSysRd,
               memInit(prevA)), $sformatf("simul%0d", k));
      prevA = a;
      prevDisp = (k < 8) || (k >= 9 && k < 17);
      prevSysRd = (k == 8);
    end

    // Display request held throughout, system port waiting: one system beat per gap.
    prevA = '0; prevDisp = 0; prevSysRd = 0;
    for (int c = 0; c <= 26; c++) begin
      dreq  = (c <= 18);
      sval  = (c >= 3 && c <= 17);
      sAddr = (c <= 8) ? 14'h0020 : 14'h0021;
      ack   = (c == 0 || c == 9 || c == 18);
      rdy   = (c == 8 || c == 17 || c == 26);
      s     = (c >= 18) ? 18 : (c >= 9) ? 9 : 0;
      if (c == 8) a = 14'h0020;
      else if (c == 17) a = 14'h0021;
      else if (c == 26) a = '0;
      else a = 14'h0200 + ADDRW'(c - s);
      drv = prevDisp;
      srv = prevSysRd;
      cycle(mk(dreq, 14'h0200, sval, 0, sAddr, 0, ack, rdy, a, 0, drv, srv, memInit(prevA)),
            $sformatf("fair%0d", c));
      prevA = a;
      prevDisp = !(c == 8 || c == 17 || c == 26);
      prevSysRd = (c == 8 || c == 17);
    end

`ifdef VRAM_ARB_STATS_EN
    expStall = 21;
    expBursts = 7;
`else
    expStall = 0;
    expBursts = 0;
`endif
    checkOutput("stats.sys_stall", 32'(bus.stat_sys_stall), 32'(expStall));
    checkOutput("stats.bursts", 32'(bus.stat_bursts), 32'(expBursts));

    // Reset dropped in the middle of a burst aborts it at once.
    cycle(mk(1, 14'h0400, 0, 0, 0, 0, 1, 0, 14'h0400, 0, 0, 0, 0), "abort0");
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 14'h0401, 0, 1, 0, memInit(14'h0400)), "abort1");
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 14'h0402, 0, 1, 0, memInit(14'h0401)), "abort2");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort.disp_rvalid", 32'(bus.disp_rvalid), 32'd0);
    checkOutput("abort.mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("abort.sys_ready", 32'(bus.sys_ready), 32'd1);
    checkOutput("abort.stat_bursts", 32'(bus.stat_bursts), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "post0");
    cycle(mk(1, 14'h0500, 0, 0, 0, 0, 1, 0, 14'h0500, 0, 0, 0, 0), "post1");
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 14'h0501, 0, 1, 0, memInit(14'h0500)), "post2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port canvas bitmap memory arbiter between the display line fetcher and the system (CPU or drawing) port. The display side has priority and reads fixed-length bursts. The system side gets single-beat read/write transfers in the gaps. A fairness rule guarantees the system port one transfer between consecutive display bursts, so it is never starved. The block sits between the canvas bitmap BRAM (synchronous read, 1-cycle latency) and the display pipeline of each chapter top.

## Interface
Parameters:
- ADDRW, 14: memory word-address width (bits)
- DATAW, 32: memory word width (bits)
- BURST, 8: words per display burst (≥2)

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst_n  in  1  reset; one clock, asynchronous, active-low
- disp_req  in  1  display burst request; hold until disp_ack
- disp_addr  in  ADDRW  burst start address; stable while disp_req high
- disp_ack  out  1  burst accepted (combinational, one cycle)
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  DATAW  display read data
- sys_valid  in  1  system transfer request; hold until sys_ready
- sys_ready  out  1  system transfer accepted this cycle (combinational)
- sys_we  in  1  1 = write, 0 = read
- sys_addr  in  ADDRW  system address
- sys_wdata  in  DATAW  system write data
- sys_rvalid  out  1  system read data valid
- sys_rdata  out  DATAW  system read data
- mem_addr  out  ADDRW  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATAW  memory write data
- mem_rdata  in  DATAW  memory read data, valid 1 cycle after mem_addr
- stat_sys_stall  out  16  system stall cycle count (see Configuration)
- stat_bursts  out  16  completed display bursts (see Configuration)

## Operation
- State machine: IDLE, BURST. Additional register: sys_owed flag and beat counter cnt (clog2(BURST) bits).
- IDLE, grant rule: display wins if disp_req && !(sys_owed && sys_valid); otherwise sys_ready = sys_valid-independent 1.
  - sys_ready = IDLE && (!disp_req || sys_owed).
- Display grant in IDLE:
  - disp_ack=1; beat 0 issued same cycle (mem_addr=disp_addr).
  - Latch base, cnt←1, go BURST.
- BURST:
  - mem_addr = base+cnt, modulo 2^ADDRW (wraps at top of memory).
  - cnt increments each cycle. After beat BURST-1 is issued, return to IDLE.
  - sys_ready=0 and disp_ack=0 throughout.
- On leaving BURST: sys_owed←sys_valid.
- System transfer (sys_valid && sys_ready):
  - mem_addr=sys_addr, mem_we=sys_we, mem_wdata=sys_wdata.
  - Reads raise sys_rvalid next cycle; writes produce no response.
  - Clears sys_owed.
- In IDLE with sys_valid low, sys_owed clears.
- Idle outputs: mem_addr=0, mem_we=0, mem_wdata=0.
- mem_we is only ever high for system writes. Display beats are always reads.
- Read data: disp_rdata and sys_rdata both carry the registered mem_rdata path. Only the matching rvalid qualifies it.

## Timing
- Reset values: state IDLE, sys_owed 0, cnt 0, disp_rvalid 0, sys_rvalid 0, stat counters 0. Combinational outputs follow from IDLE with no requests.
- Display burst accepted at cycle t:
  - beat k issued at t+k, disp_rvalid high t+1..t+BURST.
  - IDLE again at t+BURST.
- Back-to-back bursts give 100% memory utilisation, one burst per BURST cycles, unless sys owed.
- System read accepted at t: sys_rvalid at t+1, single cycle.
- System write: memory updated at t. A display beat issued at t+1 to the same address returns the new data.
- Simultaneous disp_req and sys_valid in IDLE:
  - Display wins, unless sys_owed. In that case system wins, display acks at t+1.
- Reset asserted mid-burst:
  - Immediate abort; rvalids drop asynchronously.
  - No further beats; the display requester must re-request.

## Configuration
- VRAM_ARB_STATS_EN defined:
  - stat_sys_stall counts cycles with sys_valid && !sys_ready, saturating at 16'hFFFF.
  - stat_bursts counts completed display bursts, wrapping at 2^16.
- Not defined: both stat outputs are constant 0, and no counter logic is present.

## Test plan
- Reset, then idle: all outputs 0 with sys_ready=1. Assert rst_n=0 mid-burst: disp_rvalid=0 immediately, and after release state is IDLE.
- disp_req with disp_addr=0x0100, BURST=8 → disp_ack 1 cycle; mem_addr 0x0100..0x0107 on consecutive cycles; 8 disp_rvalid beats starting one cycle later, data matching memory.
- disp_addr=0x3FFC, ADDRW=14 → mem_addr sequence 0x3FFC..0x3FFF, 0x0000..0x0003.
- sys write 0xDEADBEEF @0x0010, then sys read @0x0010 → sys_rvalid one cycle after acceptance with 0xDEADBEEF; mem_we high only on the write cycle.
- disp_req held continuously and sys_valid asserted mid-burst → exactly one sys transfer between each pair of bursts. With stats enabled, stat_sys_stall equals the cycles sys_valid was held before ready.
- Simultaneous disp_req and sys_valid from IDLE with sys_owed=0 → display acked first, then sys transfer in the cycle after the burst ends, then the next display ack.
